// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared TDC constants, width helper and result record
package tdc_pkg;

  localparam int TDC_TAPS_DEFAULT = 64;

  function automatic int tdc_count_w(input int taps);
    return $clog2(taps + 1);
  endfunction

  localparam int TDC_CW_DEFAULT = tdc_count_w(TDC_TAPS_DEFAULT);

  // Result record consumed by the coarse/fine timestamp combiner.
  typedef struct packed {
    logic [TDC_CW_DEFAULT-1:0] count;
    logic                      overflow;
    logic                      underflow;
    logic                      bubble;
  } tdc_result_t;

endpackage

// File: rtl/tdc_thermo_to_bin.sv
// rtl/tdc_thermo_to_bin.sv - first-zero search of a thermometer code with edge-range flags
module tdc_thermo_to_bin
  import tdc_pkg::*;
#(
  parameter int TAPS = TDC_TAPS_DEFAULT,
  parameter int CW   = tdc_count_w(TAPS)
) (
  input  logic [TAPS-1:0] therm_i,
  output logic [CW-1:0]   count_o,
  output logic            overflow_o,
  output logic            underflow_o
);

  // Scanning downward leaves the lowest zero index; ones above it are ignored.
  always_comb begin
    count_o = CW'(TAPS);
    for (int i = TAPS - 1; i >= 0; i--) begin
      if (!therm_i[i]) count_o = CW'(i);
    end
  end

  assign overflow_o  = &therm_i;
  assign underflow_o = ~therm_i[0];

endmodule

// File: rtl/tdc_thermo_encoder.sv
// rtl/tdc_thermo_encoder.sv - delay-line tap capture, bubble filter and thermometer-to-binary pipeline
module tdc_thermo_encoder
  import tdc_pkg::*;
#(
  parameter int TAPS          = TDC_TAPS_DEFAULT,
  parameter int CW            = tdc_count_w(TAPS),
  parameter int SYNC_STAGES   = 2,
  parameter bit BUBBLE_FILTER = 1'b1,
  parameter bit POLARITY      = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [TAPS-1:0] taps_in,
  input  logic            sample,
  output logic [CW-1:0]   fine_count,
  output logic            valid,
  output logic            overflow,
  output logic            underflow,
  output logic            bubble
);

  logic [TAPS-1:0]        sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] samp_q;

  always_ff @(posedge clk) begin
    sync_q[0] <= taps_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_q <= '0;
    end else begin
      samp_q[0] <= sample;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        samp_q[i] <= samp_q[i-1];
      end
    end
  end

  logic [TAPS-1:0] t_d;
  logic [TAPS+1:0] ext_d;
  logic [TAPS-1:0] f_d;
  logic            bubble_d;

  assign t_d   = POLARITY ? sync_q[SYNC_STAGES-1] : ~sync_q[SYNC_STAGES-1];
  // Boundaries: a virtual 1 below tap 0 and a virtual 0 above the last tap.
  assign ext_d = {1'b0, t_d, 1'b1};

  always_comb begin
    f_d      = t_d;
    bubble_d = 1'b0;
    if (BUBBLE_FILTER) begin
      for (int i = 0; i < TAPS; i++) begin
        f_d[i] = (ext_d[i] & ext_d[i+1]) | (ext_d[i] & ext_d[i+2]) | (ext_d[i+1] & ext_d[i+2]);
      end
      bubble_d = |(f_d ^ t_d);
    end
  end

  logic [TAPS-1:0] f_q;
  logic            bubble_q;
  logic            fvld_q;

  always_ff @(posedge clk) begin
    f_q      <= f_d;
    bubble_q <= bubble_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) fvld_q <= 1'b0;
    else        fvld_q <= samp_q[SYNC_STAGES-1];
  end

  logic [CW-1:0] enc_count;
  logic          enc_ovf;
  logic          enc_udf;

  tdc_thermo_to_bin #(
    .TAPS (TAPS),
    .CW   (CW)
  ) u_thermo_to_bin (
    .therm_i     (f_q),
    .count_o     (enc_count),
    .overflow_o  (enc_ovf),
    .underflow_o (enc_udf)
  );

  logic [CW-1:0] count_q;
  logic          valid_q;
  logic          ovf_q;
  logic          udf_q;
  logic          bub_q;

  // Result registers only load on a valid sample so they hold between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      bub_q   <= 1'b0;
    end else begin
      valid_q <= fvld_q;
      if (fvld_q) begin
        count_q <= enc_count;
        ovf_q   <= enc_ovf;
        udf_q   <= enc_udf;
        bub_q   <= bubble_q;
      end
    end
  end

  assign fine_count = count_q;
  assign valid      = valid_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;
  assign bubble     = bub_q;

endmodule
